spatz_vreg_chain_sb: RTL and testbench

Parametrised vector-register scoreboard with element-level chaining.
- Sits between the controller issue stage and the VRF ports.
- Each write port (VFU, VLSU, VSLDU, ...) owns at most one destination register at a time.
- Read-port requests to a reserved register are granted only for elements the writer has already produced. Dependent units can therefore chain instead of waiting for retirement.
- Generalises the fixed 5-read/3-write port set to arbitrary port counts and register geometry.

---
 rtl/spatz_vreg_chain_sb_if.sv | 41 ++++
 rtl/spatz_vreg_chain_sb.sv | 141 ++++++++++++++
 tb/tb_spatz_vreg_chain_sb.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/spatz_vreg_chain_sb_if.sv
// Issue/write/read port bundle between the controller and the chaining scoreboard.
// The controller drives the master side; the scoreboard sits on the slave side.
interface spatz_vreg_chain_sb_if #(
  parameter int NrRdPorts = 5,
  parameter int NrWrPorts = 3,
  parameter int NrVReg    = 32,
  parameter int NrEle     = 4,
  parameter int IdWidth   = 5
);
  localparam int RegW  = $clog2(NrVReg);
  localparam int EleW  = $clog2(NrEle);
  localparam int AddrW = RegW + EleW;
  localparam int WpW   = (NrWrPorts > 1) ? $clog2(NrWrPorts) : 1;

  logic                           issue_valid_i;
  logic                           issue_ready_o;
  logic [RegW-1:0]                issue_vd_i;
  logic [WpW-1:0]                 issue_wport_i;
  logic [IdWidth-1:0]             issue_id_i;
  logic [NrWrPorts-1:0]           wr_valid_i;
  logic [NrWrPorts*AddrW-1:0]     wr_addr_i;
  logic [NrWrPorts-1:0]           retire_i;
  logic [NrRdPorts-1:0]           rd_req_i;
  logic [NrRdPorts*AddrW-1:0]     rd_addr_i;
  logic [NrRdPorts-1:0]           rd_gnt_o;
  logic [NrVReg-1:0]              busy_o;
  logic [NrWrPorts*IdWidth-1:0]   wp_id_o;
  logic                           err_o;

  modport master (
    output issue_valid_i, issue_vd_i, issue_wport_i, issue_id_i,
    output wr_valid_i, wr_addr_i, retire_i, rd_req_i, rd_addr_i,
    input  issue_ready_o, rd_gnt_o, busy_o, wp_id_o, err_o
  );

  modport slave (
    input  issue_valid_i, issue_vd_i, issue_wport_i, issue_id_i,
    input  wr_valid_i, wr_addr_i, retire_i, rd_req_i, rd_addr_i,
    output issue_ready_o, rd_gnt_o, busy_o, wp_id_o, err_o
  );
endinterface

// File: rtl/spatz_vreg_chain_sb.sv
// Vector-register scoreboard: one reservation per write port, with element-level
// progress tracking so readers can chain on elements already produced.
module spatz_vreg_chain_sb #(
  parameter int NrRdPorts = 5,
  parameter int NrWrPorts = 3,
  parameter int NrVReg    = 32,
  parameter int NrEle     = 4,
  parameter int IdWidth   = 5
) (
  input logic                clk_i,
  input logic                rst_i,
  spatz_vreg_chain_sb_if.slave sb
);
  localparam int RegW  = $clog2(NrVReg);
  localparam int EleW  = $clog2(NrEle);
  localparam int AddrW = RegW + EleW;
  localparam int WpW   = (NrWrPorts > 1) ? $clog2(NrWrPorts) : 1;
  localparam int PrgW  = EleW + 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  logic [NrWrPorts-1:0]      active;
  logic [NrWrPorts-1:0]      wr_err;
  logic [NrWrPorts-1:0]      rt_err;
  logic [NrWrPorts*RegW-1:0] vd_flat;
  logic [NrWrPorts*PrgW-1:0] prog_flat;
  logic                      issue_fire;
  logic                      err_reg, err_next;

  assign issue_fire = sb.issue_valid_i & sb.issue_ready_o;

  for (genvar gi = 0; gi < NrWrPorts; gi++) begin : g_wport
    state_e             state_reg, state_next;
    logic [RegW-1:0]    vd_reg, vd_next;
    logic [IdWidth-1:0] id_reg, id_next;
    logic [PrgW-1:0]    prog_reg, prog_next;
    logic [RegW-1:0]    wr_vreg;
    logic [EleW-1:0]    wr_ele;
    logic               hit;

    assign {wr_vreg, wr_ele} = sb.wr_addr_i[gi*AddrW +: AddrW];
    assign hit = issue_fire && (sb.issue_wport_i == WpW'(gi));

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_reg <= IDLE;
        vd_reg    <= '0;
        id_reg    <= '0;
        prog_reg  <= '0;
      end else begin
        state_reg <= state_next;
        vd_reg    <= vd_next;
        id_reg    <= id_next;
        prog_reg  <= prog_next;
      end
    end

    // Forward writes raise progress to ele+1 (never past NrEle); rewrites leave it alone.
    always_comb begin
      state_next = state_reg;
      vd_next    = vd_reg;
      id_next    = id_reg;
      prog_next  = prog_reg;
      wr_err[gi] = 1'b0;
      rt_err[gi] = 1'b0;
      if (sb.wr_valid_i[gi]) begin
        if (state_reg == ACTIVE && wr_vreg == vd_reg) begin
          if ({1'b0, wr_ele} >= prog_reg)
            prog_next = {1'b0, wr_ele} + PrgW'(1);
        end else begin
          wr_err[gi] = 1'b1;
        end
      end
      if (sb.retire_i[gi]) begin
        if (state_reg == ACTIVE) begin
          state_next = IDLE;
          prog_next  = '0;
        end else begin
          rt_err[gi] = 1'b1;
        end
      end
      if (hit) begin
        state_next = ACTIVE;
        vd_next    = sb.issue_vd_i;
        id_next    = sb.issue_id_i;
        prog_next  = '0;
      end
    end

    assign active[gi]                        = (state_reg == ACTIVE);
    assign vd_flat[gi*RegW +: RegW]          = vd_reg;
    assign prog_flat[gi*PrgW +: PrgW]        = prog_reg;
    assign sb.wp_id_o[gi*IdWidth +: IdWidth] = id_reg;
  end

  assign err_next = err_reg | (|wr_err) | (|rt_err);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_reg <= 1'b0;
    else       err_reg <= err_next;
  end

  logic                 sel_idle, waw, blocked;
  logic [NrVReg-1:0]    busy_c;
  logic [NrRdPorts-1:0] gnt_c;
  logic [RegW-1:0]      rd_vreg;
  logic [EleW-1:0]      rd_ele;

  // Grants and ready look only at registered state, so a same-cycle write or
  // retire never takes effect until the following cycle.
  always_comb begin
    sel_idle = 1'b0;
    waw      = 1'b0;
    blocked  = 1'b0;
    busy_c   = '0;
    gnt_c    = '0;
    rd_vreg  = '0;
    rd_ele   = '0;
    for (int p = 0; p < NrWrPorts; p++) begin
      if (sb.issue_wport_i == WpW'(p) && !active[p]) sel_idle = 1'b1;
      if (active[p] && vd_flat[p*RegW +: RegW] == sb.issue_vd_i) waw = 1'b1;
      if (active[p]) busy_c[vd_flat[p*RegW +: RegW]] = 1'b1;
    end
    for (int r = 0; r < NrRdPorts; r++) begin
      {rd_vreg, rd_ele} = sb.rd_addr_i[r*AddrW +: AddrW];
      blocked = 1'b0;
      for (int p = 0; p < NrWrPorts; p++) begin
        if (active[p] && vd_flat[p*RegW +: RegW] == rd_vreg &&
            {1'b0, rd_ele} >= prog_flat[p*PrgW +: PrgW])
          blocked = 1'b1;
      end
      gnt_c[r] = sb.rd_req_i[r] & ~blocked;
    end
  end

  assign sb.issue_ready_o = sel_idle & ~waw & ~rst_i;
  assign sb.rd_gnt_o      = gnt_c;
  assign sb.busy_o        = busy_c;
  assign sb.err_o         = err_reg;

endmodule

// File: tb/tb_spatz_vreg_chain_sb.sv
// Directed bench for the chaining scoreboard: default geometry plus a
// 2-read / 1-write / 8-element instance for the element sweep.
module tb_spatz_vreg_chain_sb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  spatz_vreg_chain_sb_if #(.NrRdPorts(5), .NrWrPorts(3), .NrVReg(32), .NrEle(4), .IdWidth(5)) bus ();
  spatz_vreg_chain_sb_if #(.NrRdPorts(2), .NrWrPorts(1), .NrVReg(32), .NrEle(8), .IdWidth(5)) bus8 ();

  spatz_vreg_chain_sb #(.NrRdPorts(5), .NrWrPorts(3), .NrVReg(32), .NrEle(4), .IdWidth(5)) dut (
    .clk_i(clk), .rst_i(rst), .sb(bus)
  );
  spatz_vreg_chain_sb #(.NrRdPorts(2), .NrWrPorts(1), .NrVReg(32), .NrEle(8), .IdWidth(5)) dut8 (
    .clk_i(clk), .rst_i(rst), .sb(bus8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.issue_valid_i = 1'b0; bus.issue_vd_i = '0; bus.issue_wport_i = '0; bus.issue_id_i = '0;
    bus.wr_valid_i = '0; bus.wr_addr_i = '0; bus.retire_i = '0;
    bus.rd_req_i = '0; bus.rd_addr_i = '0;
    bus8.issue_valid_i = 1'b0; bus8.issue_vd_i = '0; bus8.issue_wport_i = '0; bus8.issue_id_i = '0;
    bus8.wr_valid_i = '0; bus8.wr_addr_i = '0; bus8.retire_i = '0;
    bus8.rd_req_i = '0; bus8.rd_addr_i = '0;
  endtask

  task automatic issue(input int p, input int v, input int id);
    bus.issue_valid_i = 1'b1; bus.issue_wport_i = 2'(p);
    bus.issue_vd_i = 5'(v); bus.issue_id_i = 5'(id);
    $display("[TB] issue port %0d v%0d id %0d", p, v, id);
  endtask

  task automatic set_wr(input int p, input int v, input int e);
    bus.wr_valid_i[p] = 1'b1;
    bus.wr_addr_i[p*7 +: 7] = {5'(v), 2'(e)};
    $display("[TB] write port %0d {%0d,%0d}", p, v, e);
  endtask

  task automatic set_rd(input int r, input int v, input int e);
    bus.rd_req_i[r] = 1'b1;
    bus.rd_addr_i[r*7 +: 7] = {5'(v), 2'(e)};
  endtask

  task automatic set_rd8(input int r, input int v, input int e);
    bus8.rd_req_i[r] = 1'b1;
    bus8.rd_addr_i[r*8 +: 8] = {5'(v), 3'(e)};
  endtask

  initial begin
    idle();
    #1 rst = 1'b1;
    tick();
    issue(0, 3, 1);
    #1;
    chk("reset_ready", bus.issue_ready_o, 0);
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_err", bus.err_o, 0);
    idle();
    rst = 1'b0;
    tick();

    // Reset mid-operation: v3 on port 0 with progress 2
    issue(0, 3, 1);
    #1 chk("t1_ready", bus.issue_ready_o, 1);
    tick(); idle();
    set_wr(0, 3, 1);
    #1 chk("t1_busy", bus.busy_o, 32'h8);
    tick(); idle();
    set_rd(0, 3, 1); set_rd(1, 3, 2);
    #1 chk("t1_gnt_prog2", bus.rd_gnt_o, 5'b00001);
    rst = 1'b1;
    #1;
    chk("t1_async_busy", bus.busy_o, 0);
    chk("t1_async_err", bus.err_o, 0);
    chk("t1_async_gnt", bus.rd_gnt_o, 5'b00011);
    issue(0, 3, 1);
    #1 chk("t1_async_ready", bus.issue_ready_o, 0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    issue(0, 3, 1);
    #1 chk("t1_ready_after", bus.issue_ready_o, 1);
    idle();

    // Chaining on v5
    issue(0, 5, 2);
    tick(); idle();
    set_rd(0, 5, 0);
    #1 chk("t2_gnt_before", bus.rd_gnt_o[0], 0);
    set_wr(0, 5, 0);
    #1 chk("t2_gnt_same_cycle", bus.rd_gnt_o[0], 0);
    tick(); idle();
    set_rd(0, 5, 0); set_rd(1, 5, 1);
    #1 chk("t2_gnt_next_cycle", bus.rd_gnt_o, 5'b00001);
    set_wr(0, 5, 3);
    tick(); idle();
    set_rd(0, 5, 0); set_rd(1, 5, 1); set_rd(2, 5, 2); set_rd(3, 5, 3); set_rd(4, 6, 0);
    #1 chk("t2_gnt_all", bus.rd_gnt_o, 5'b11111);
    idle();
    set_wr(0, 5, 1);
    tick(); idle();
    set_rd(0, 5, 0); set_rd(1, 5, 1); set_rd(2, 5, 2); set_rd(3, 5, 3);
    #1;
    chk("t2_gnt_after_rewrite", bus.rd_gnt_o, 5'b01111);
    chk("t2_err_rewrite", bus.err_o, 0);
    idle();
    bus.retire_i[0] = 1'b1;
    #1 chk("t2_busy_retiring", bus.busy_o, 32'h20);
    tick(); idle();
    #1 chk("t2_busy_retired", bus.busy_o, 0);

    // WAW stall on v7
    issue(1, 7, 3);
    tick(); idle();
    issue(2, 7, 4); set_rd(0, 7, 0);
    #1;
    chk("t3_waw_ready", bus.issue_ready_o, 0);
    chk("t3_gnt_blocked", bus.rd_gnt_o[0], 0);
    bus.retire_i[1] = 1'b1;
    #1;
    chk("t3_ready_retire_t", bus.issue_ready_o, 0);
    chk("t3_gnt_retire_t", bus.rd_gnt_o[0], 0);
    tick();
    bus.retire_i = '0;
    set_rd(0, 7, 2);
    #1;
    chk("t3_ready_t1", bus.issue_ready_o, 1);
    chk("t3_gnt_t1", bus.rd_gnt_o[0], 1);
    idle();

    // Independent registers v1 / v9
    issue(0, 1, 12);
    tick();
    issue(2, 9, 17);
    tick(); idle();
    set_rd(0, 2, 0); set_rd(1, 1, 0); set_rd(2, 9, 1);
    #1;
    chk("t4_gnt", bus.rd_gnt_o, 5'b00001);
    chk("t4_busy", bus.busy_o, 32'h0000_0202);
    chk("t4_wp_id", bus.wp_id_o, {5'd17, 5'd3, 5'd12});
    idle();
    bus.retire_i = 3'b101;
    tick(); idle();
    #1 chk("t4_busy_clear", bus.busy_o, 0);

    // Protocol errors
    set_wr(1, 4, 0);
    #1 chk("t5_err_same_cycle", bus.err_o, 0);
    tick(); idle();
    #1 chk("t5_err_idle_write", bus.err_o, 1);
    issue(1, 4, 5);
    tick(); idle();
    set_wr(1, 4, 0);
    tick(); idle();
    set_rd(0, 4, 0);
    #1;
    chk("t5_err_sticky", bus.err_o, 1);
    chk("t5_gnt_legal", bus.rd_gnt_o[0], 1);
    idle();
    bus.retire_i[1] = 1'b1;
    tick(); idle();
    rst = 1'b1;
    #1 chk("t5_err_reset", bus.err_o, 0);
    tick();
    rst = 1'b0;
    tick();
    issue(3, 10, 1);
    #1 chk("t5_wport_range", bus.issue_ready_o, 0);
    idle();
    bus.retire_i[2] = 1'b1;
    #1 chk("t5_err_retire_t", bus.err_o, 0);
    tick(); idle();
    #1 chk("t5_err_idle_retire", bus.err_o, 1);

    // Eight-element sweep on the single-write-port instance
    bus8.issue_valid_i = 1'b1; bus8.issue_vd_i = 5'd0; bus8.issue_wport_i = 1'b0; bus8.issue_id_i = 5'd7;
    #1 chk("t6_ready", bus8.issue_ready_o, 1);
    tick(); idle();
    for (int k = 0; k < 8; k++) begin
      bus8.wr_valid_i[0] = 1'b1;
      bus8.wr_addr_i = {5'd0, 3'(k)};
      $display("[TB] sweep write {0,%0d}", k);
      set_rd8(0, 0, k);
      if (k > 0) set_rd8(1, 0, k - 1);
      #1;
      chk($sformatf("t6_gnt_same_%0d", k), bus8.rd_gnt_o[0], 0);
      if (k > 0) chk($sformatf("t6_gnt_prev_%0d", k - 1), bus8.rd_gnt_o[1], 1);
      tick(); idle();
    end
    set_rd8(0, 1, 0); set_rd8(1, 0, 7);
    #1;
    chk("t6_gnt_last", bus8.rd_gnt_o, 2'b11);
    chk("t6_busy", bus8.busy_o, 32'h1);
    chk("t6_wp_id", bus8.wp_id_o, 5'd7);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
